// File: rtl/control_unit_param.sv
// Parametrised simple-processor control unit: fetch on Run, execute mv/mvi/ALU ops over 2-4 steps.
// Optional `define CU_MVNZ_EN turns opcode 111 into mvnz; otherwise it is a NOP.
module control_unit_param #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 5
) (
    input  logic              Pclk,
    input  logic              Reset,
    input  logic              Run,
    input  logic [DATA_W-1:0] din,
    output logic              Done,
    output logic [DATA_W-1:0] bus,
    output logic              zero,
    output logic [CNT_W-1:0]  counter
);
    localparam int NREG = 2 ** REG_AW;
    localparam int IW   = 3 + 2 * REG_AW;

    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;
    typedef enum logic [2:0] {
        OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MVNZ
    } op_t;

    state_t             state_q;
    logic [IW-1:0]      ir_q;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  g_q;
    logic [DATA_W-1:0]  r_q [NREG];
    logic               zero_q;
    logic [CNT_W-1:0]   cnt_q;

    op_t                op;
    logic [REG_AW-1:0]  rx;
    logic [REG_AW-1:0]  ry;
    logic               is_alu;
    logic [DATA_W-1:0]  bus_c;
    logic               done_c;
    logic [DATA_W-1:0]  alu_c;
    logic               wr_c;

    assign op     = op_t'(ir_q[IW-1 -: 3]);
    assign rx     = ir_q[2*REG_AW-1 -: REG_AW];
    assign ry     = ir_q[REG_AW-1:0];
    assign is_alu = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};

    // Bus mux, Done decode and register-write enable are purely a function of step and opcode.
    always_comb begin
        bus_c  = '0;
        done_c = 1'b0;
        wr_c   = 1'b0;
        unique case (state_q)
            T1: begin
                case (op)
                    OP_MV: begin
                        bus_c  = r_q[ry];
                        done_c = 1'b1;
                        wr_c   = 1'b1;
                    end
                    OP_MVI: begin
                        bus_c  = din;
                        done_c = 1'b1;
                        wr_c   = 1'b1;
                    end
                    OP_MVNZ: begin
`ifdef CU_MVNZ_EN
                        bus_c  = r_q[ry];
                        wr_c   = (g_q != '0);
`endif
                        done_c = 1'b1;
                    end
                    default: bus_c = r_q[rx];
                endcase
            end
            T2: bus_c = r_q[ry];
            T3: begin
                bus_c  = g_q;
                done_c = 1'b1;
                wr_c   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_c = '0;
        case (op)
            OP_ADD:  alu_c = a_q + bus_c;
            OP_SUB:  alu_c = a_q - bus_c;
            OP_AND:  alu_c = a_q & bus_c;
            OP_OR:   alu_c = a_q | bus_c;
            OP_XOR:  alu_c = a_q ^ bus_c;
            default: alu_c = '0;
        endcase
    end

    always_ff @(posedge Pclk or posedge Reset) begin
        if (Reset) begin
            state_q <= T0;
            ir_q    <= '0;
            a_q     <= '0;
            g_q     <= '0;
            r_q     <= '{default: '0};
            zero_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (wr_c) r_q[rx] <= bus_c;
            unique case (state_q)
                T0: begin
                    if (Run) begin
                        ir_q    <= din[IW-1:0];
                        state_q <= T1;
                    end
                end
                T1: begin
                    if (is_alu) begin
                        a_q     <= bus_c;
                        state_q <= T2;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        state_q <= T0;
                    end
                end
                T2: begin
                    g_q     <= alu_c;
                    zero_q  <= (alu_c == '0);
                    state_q <= T3;
                end
                T3: begin
                    cnt_q   <= cnt_q + CNT_W'(1);
                    state_q <= T0;
                end
                default: state_q <= T0;
            endcase
        end
    end

    assign Done    = done_c;
    assign bus     = bus_c;
    assign zero    = zero_q;
    assign counter = cnt_q;
endmodule

// File: tb/tb_control_unit_param.sv
// Scoreboard bench for control_unit_param: driver pushes model predictions, monitor checks each Done cycle.
module tb_control_unit_param;
    localparam int DATA_W = 16;
    localparam int REG_AW = 3;
    localparam int CNT_W  = 5;
    localparam int NREG   = 2 ** REG_AW;
    localparam int IW     = 3 + 2 * REG_AW;

    logic              Pclk = 1'b0;
    logic              Reset;
    logic              Run;
    logic [DATA_W-1:0] din;
    logic              Done;
    logic [DATA_W-1:0] bus;
    logic              zero;
    logic [CNT_W-1:0]  counter;

    control_unit_param #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .Pclk(Pclk), .Reset(Reset), .Run(Run), .din(din),
        .Done(Done), .bus(bus), .zero(zero), .counter(counter)
    );

    always #5 Pclk = ~Pclk;

    typedef struct {
        logic [DATA_W-1:0] bus;
        logic              zero;
        logic [CNT_W-1:0]  cnt;
        int                cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   busy = 1'b0;

    // Reference state: architectural registers only.
    logic [DATA_W-1:0] m_r [NREG];
    logic [DATA_W-1:0] m_g;
    logic              m_zero;
    int                m_cnt;

    always @(posedge Pclk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_r[i] = '0;
        m_g = '0;
        m_zero = 1'b0;
        m_cnt = 0;
    endtask

    // Monitor: compares every Done cycle against the oldest prediction; idle cycles must be quiet.
    always @(negedge Pclk) begin
        if (!Reset) begin
            if (Done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("bus", 32'(bus), 32'(e.bus));
                    chk("zero", 32'(zero), 32'(e.zero));
                    chk("counter", 32'(counter), 32'(e.cnt));
                    chk("done_latency", 32'(cyc), 32'(e.cyc));
                end
            end
            if (!busy) begin
                chk("idle_done", 32'(Done), 32'd0);
                chk("idle_bus", 32'(bus), 32'd0);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input int rx, input int ry, input logic [DATA_W-1:0] imm);
        logic [DATA_W-1:0] w, res, a, b;
        logic [REG_AW-1:0] x, y;
        int lat;
        exp_t e;
        x = rx[REG_AW-1:0];
        y = ry[REG_AW-1:0];
        w = DATA_W'($urandom);
        w[IW-1:0] = {op, x, y};
        @(negedge Pclk);
        Run = 1'b1;
        din = w;
        @(posedge Pclk);
        #1;
        Run = 1'b0;
        din = imm;
        busy = 1'b1;
        a = m_r[x];
        b = m_r[y];
        lat = 3;
        case (op)
            3'b000: begin res = b; m_r[x] = b; lat = 1; end
            3'b001: begin res = imm; m_r[x] = imm; lat = 1; end
            3'b010: res = a + b;
            3'b011: res = a - b;
            3'b100: res = a & b;
            3'b101: res = a | b;
            3'b110: res = a ^ b;
            default: begin
                lat = 1;
`ifdef CU_MVNZ_EN
                res = b;
                if (m_g != '0) m_r[x] = b;
`else
                res = '0;
`endif
            end
        endcase
        if (lat == 3) begin
            m_g = res;
            m_zero = (res == '0);
            m_r[x] = res;
        end
        e.bus = res;
        e.zero = m_zero;
        e.cnt = CNT_W'(m_cnt);
        e.cyc = cyc + lat - 1;
        q.push_back(e);
        m_cnt++;
        repeat (lat) @(posedge Pclk);
        #1;
        busy = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        Run = 1'b0;
        din = '0;
        model_reset();
        #20;
        Reset = 1'b0;
        #1;
        chk("rst_bus", 32'(bus), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_counter", 32'(counter), 32'd0);
        repeat (4) @(posedge Pclk);
        #1;
        chk("idle_counter", 32'(counter), 32'd0);

        // mvi / mv
        issue(3'b001, 0, 0, 16'h1234);
        issue(3'b000, 1, 0, 16'hAAAA);
        issue(3'b000, 2, 1, 16'h5555);
        chk("counter_after_3", 32'(counter), 32'd3);

        // add wrap and sub to zero
        issue(3'b001, 2, 0, 16'hFFFF);
        issue(3'b001, 3, 0, 16'h0001);
        issue(3'b010, 2, 3, 16'h0);
        issue(3'b011, 3, 3, 16'h0);
        issue(3'b000, 0, 2, 16'h0);
        issue(3'b000, 0, 3, 16'h0);

        // logic ops with reload
        issue(3'b001, 5, 0, 16'h00FF);
        for (int k = 0; k < 3; k++) begin
            issue(3'b001, 4, 0, 16'h0F0F);
            issue(3'(3'b100 + k), 4, 5, 16'h0);
        end
        issue(3'b010, 6, 6, 16'h0);

        // reset in T2 of an add
        issue(3'b001, 6, 0, 16'h0042);
        @(negedge Pclk);
        Run = 1'b1;
        din = '0;
        din[IW-1:0] = {3'b010, 3'd6, 3'd6};
        @(posedge Pclk);
        #1;
        Run = 1'b0;
        busy = 1'b1;
        @(posedge Pclk);
        #1;
        Reset = 1'b1;
        #1;
        chk("abort_done", 32'(Done), 32'd0);
        chk("abort_bus", 32'(bus), 32'd0);
        chk("abort_counter", 32'(counter), 32'd0);
        chk("abort_zero", 32'(zero), 32'd0);
        @(negedge Pclk);
        Reset = 1'b0;
        busy = 1'b0;
        model_reset();
        for (int i = 0; i < NREG; i++) issue(3'b000, 7, i, 16'h0);

        // counter wrap with back-to-back mv
        for (int i = 0; i < 32; i++) issue(3'b000, $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1), 16'h0);
        chk("counter_wrap", 32'(counter), 32'(CNT_W'(NREG + 32)));

        // op 111 with G == 0 then G != 0
        issue(3'b001, 1, 0, 16'h0077);
        issue(3'b001, 2, 0, 16'h0099);
        issue(3'b011, 3, 3, 16'h0);
        issue(3'b111, 2, 1, 16'h0);
        issue(3'b000, 0, 2, 16'h0);
        issue(3'b010, 3, 1, 16'h0);
        issue(3'b111, 2, 1, 16'h0);
        issue(3'b000, 0, 2, 16'h0);

        // randomized mix
        for (int i = 0; i < 300; i++)
            issue(3'($urandom_range(0, 7)), $urandom_range(0, NREG - 1),
                  $urandom_range(0, NREG - 1), DATA_W'($urandom));

        repeat (3) @(posedge Pclk);
        #1;
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/control_unit_param.md
Name: control_unit_param

Overview:
- Parametrised successor to the team's fixed 16-bit, 8-register simple processor control unit.
- Accepts one instruction word on din when Run is pulsed, executes it over 2–4 Pclk steps on an internal register file, drives the shared bus, and flags Done.
- New over the fixed version:
  - generic data width and register count;
  - AND/OR/XOR ALU ops;
  - zero flag;
  - retired-instruction counter;
  - optional conditional move.

Parameters:
- DATA_W, 16: width of registers, A, G, din and bus.
- REG_AW, 3: register address bits. NREG = 2**REG_AW registers.
- CNT_W, 5: width of the retired-instruction counter.

Ports:
- Pclk  input  1  single clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high; clears all state immediately.
- Run  input  1  start strobe, sampled only in state T0.
- din  input  DATA_W  instruction word in T0 (low 3+2*REG_AW bits used); immediate data in T1 for mvi.
- Done  output  1  high for the final step of the current instruction.
- bus  output  DATA_W  current bus mux value.
- zero  output  1  set when the last ALU result written to G was 0.
- counter  output  CNT_W  number of instructions retired, modulo 2**CNT_W.

Behaviour:
- Reset values:
  - state T0;
  - IR, A, G, all R[i] = 0;
  - zero = 0, counter = 0;
  - Done = 0, bus = 0.
  - Reset asserted mid-instruction aborts it with no partial writes after the asserting edge, and does not count it.
- Instruction format: IR = {op[2:0], rx[REG_AW-1:0], ry[REG_AW-1:0]}, taken from din[3+2*REG_AW-1:0]. Upper din bits are ignored.
- Opcodes:
  - 000 mv: rx <- ry.
  - 001 mvi: rx <- din.
  - 010 add.
  - 011 sub.
  - 100 and.
  - 101 or.
  - 110 xor.
  - 111 mvnz: see Optional Feature.
- FSM states T0 (idle/fetch), T1, T2, T3. The step advances every Pclk edge outside T0.
- T0:
  - If Run=1 at the edge, IR <- din and go to T1; otherwise stay in T0.
  - Done=0, bus=0.
  - Run in any other state is ignored; no queuing.
- mv:
  - T1: bus = R[ry], R[rx] <- bus, Done=1.
  - Next state T0.
- mvi:
  - T1: bus = din (sampled this cycle), R[rx] <- bus, Done=1.
  - Next state T0.
- ALU ops:
  - T1: bus = R[rx], A <- bus.
  - T2: bus = R[ry], G <- A op bus, zero <- (result==0).
  - T3: bus = G, R[rx] <- G, Done=1.
  - Next state T0.
- Latency, counted from the Run-sampling edge to the Done cycle: mv/mvi 1 cycle; ALU ops 3 cycles.
- Done is a combinational decode of state and op, high for exactly one cycle per instruction.
- counter increments on the edge that leaves the Done step; it wraps from 2**CNT_W-1 to 0.
- Arithmetic:
  - add/sub are modulo 2**DATA_W with no carry/borrow output. Example: 0xFFFF+1 = 0, zero=1.
  - sub is A - bus.
- rx == ry is legal:
  - add doubles the register;
  - sub yields 0 and sets zero=1.
- bus = 0 in any cycle with no driver.
- zero is only written by ALU ops in T2. mv, mvi and mvnz leave it unchanged.

Optional Feature:
- Macro: CU_MVNZ_EN.
- Defined: op 111 = mvnz.
  - T1: bus = R[ry]; R[rx] <- bus only if G != 0; Done=1.
  - Retires and counts whether or not the write happens.
- Undefined: op 111 is a NOP.
  - T1: bus=0, no register write, Done=1.
  - Counted as retired.

Test Plan:
1. Reset high for 20 ns, then low; sample all outputs while idle -> bus=0, Done=0, counter=0, zero=0, no state change with Run=0.
2. Run pulse with din=001_000_000 (mvi R0), then din=0x1234 in T1; follow with mv R1,R0 (000_001_000) -> R0=R1=0x1234, Done once per instruction, counter=2.
3. Load R2=0xFFFF, R3=0x0001 via mvi; run add R2,R3 (010_010_011) -> Done on 3rd cycle after Run, bus in T3 = 0x0000, R2=0, zero=1; then sub R3,R3 -> R3=0, zero=1.
4. With R4=0x0F0F and R5=0x00FF, run and/or/xor R4,R5 in turn, reloading R4 each time -> results 0x000F, 0x0FFF, 0x0FF0; zero=0 each time.
5. Assert Reset in T2 of an add -> on the same cycle state=T0, Done=0, all registers 0, counter unchanged from 0 (cleared), target register not written.
6. Run 32 back-to-back mv instructions (CNT_W=5) -> counter wraps 31->0. With CU_MVNZ_EN: mvnz with G=0 leaves rx unchanged, with G≠0 copies ry. Without CU_MVNZ_EN: op 111 leaves all registers unchanged and still gives Done=1 in T1.
